if_fetch_unit: RTL and testbench

// - Instruction-fetch front end; consumes the PC control code and redirect target produced by the pipeline controller.
// - Drives the PC, issues icache requests and buffers returned instructions.
// - Presents instructions to the IF/ID register.
// - Returns icache_data_valid_o to the controller so its branch FSM can advance.

---
 rtl/if_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch front end. Holds the PC, issues icache
//               requests under a credit limit, tags each request with its
//               PC, buffers in-order responses in a small FIFO and presents
//               them to the IF/ID register.
// Ports       : clk, rst                   - clock, async active-high reset
//               ctrl_signal_pc_i/_new_i    - PC control code and redirect target
//               icache_req_*               - request handshake and address
//               icache_resp_*              - in-order response stream
//               icache_data_valid_o        - pop pulse back to the controller
//               if_valid_o/if_ready_i      - IF/ID handshake
//               if_pc_o/if_inst_o          - presented PC and instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000,
    parameter int                MAX_OUT  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [1:0]        ctrl_signal_pc_i,
    input  wire logic [ADDR_W-1:0] ctrl_to_pc_new_i,
    output logic                   icache_req_valid_o,
    input  wire logic              icache_req_ready_i,
    output logic [ADDR_W-1:0]      icache_req_addr_o,
    input  wire logic              icache_resp_valid_i,
    input  wire logic [INST_W-1:0] icache_resp_data_i,
    output logic                   icache_data_valid_o,
    output logic                   if_valid_o,
    input  wire logic              if_ready_i,
    output logic [ADDR_W-1:0]      if_pc_o,
    output logic [INST_W-1:0]      if_inst_o
);

    localparam int              c_PTR_W    = (MAX_OUT > 2) ? 2 : 1;
    localparam int              c_CNT_W    = $clog2(2 * MAX_OUT + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUT - 1);
    localparam logic [c_CNT_W-1:0] c_MAX      = c_CNT_W'(MAX_OUT);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]  c_ALIGN    = ~ADDR_W'(3);

    localparam logic [1:0] c_CODE_DEFAULT = 2'b00;
    localparam logic [1:0] c_CODE_BRANCH  = 2'b01;
    localparam logic [1:0] c_CODE_STALL   = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [c_CNT_W-1:0]  r_out_cnt;
    logic [c_CNT_W-1:0]  r_drop_cnt;
    logic [c_CNT_W-1:0]  r_fifo_cnt;
    logic [c_PTR_W-1:0]  r_fifo_wr;
    logic [c_PTR_W-1:0]  r_fifo_rd;
    logic [c_PTR_W-1:0]  r_tag_wr;
    logic [c_PTR_W-1:0]  r_tag_rd;
    logic [ADDR_W-1:0]   r_fifo_pc   [MAX_OUT];
    logic [INST_W-1:0]   r_fifo_inst [MAX_OUT];
    logic [ADDR_W-1:0]   r_tag       [MAX_OUT];

    logic               w_branch;
    logic               w_resp;
    logic               w_credit;
    logic               w_req_valid;
    logic               w_accept;
    logic               w_drop;
    logic               w_push;
    logic               w_if_valid;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_new_drop;
    logic [c_CNT_W-1:0] w_out_next;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_comb begin
        w_branch    = (ctrl_signal_pc_i == c_CODE_BRANCH);
        // A response with nothing outstanding is a leftover from before reset.
        w_resp      = icache_resp_valid_i & (r_out_cnt != '0);
        // Outstanding requests reserve FIFO space, so responses never overflow.
        w_credit    = (r_out_cnt + r_fifo_cnt) < c_MAX;
        w_req_valid = (r_state != S_IDLE) & (ctrl_signal_pc_i != c_CODE_STALL)
                      & ~w_branch & w_credit;
        w_accept    = w_req_valid & icache_req_ready_i;
        w_drop      = w_resp & (r_drop_cnt != '0);
        w_push      = w_resp & ~w_drop & ~w_branch;
        w_if_valid  = (r_fifo_cnt != '0) & (ctrl_signal_pc_i == c_CODE_DEFAULT);
        w_pop       = w_if_valid & if_ready_i;
        // Everything still in flight after this cycle belongs to the old path.
        w_new_drop  = w_resp ? (r_out_cnt - c_ONE) : r_out_cnt;
        w_out_next  = r_out_cnt;
        if (w_accept && !w_resp) begin
            w_out_next = r_out_cnt + c_ONE;
        end else if (!w_accept && w_resp) begin
            w_out_next = r_out_cnt - c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_fifo_cnt <= '0;
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_inst[i] <= '0;
                r_tag[i]       <= '0;
            end
        end else begin
            r_out_cnt <= w_out_next;

            case (r_state)
                S_IDLE:  r_state <= S_RUN;
                S_RUN:   if (w_branch && w_new_drop != '0) r_state <= S_FLUSH;
                S_FLUSH: begin
                    if (w_branch) begin
                        r_state <= (w_new_drop != '0) ? S_FLUSH : S_RUN;
                    end else if (r_drop_cnt == '0) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_branch) begin
                r_pc       <= ctrl_to_pc_new_i & c_ALIGN;
                r_drop_cnt <= w_new_drop;
                r_fifo_cnt <= '0;
                r_fifo_wr  <= '0;
                r_fifo_rd  <= '0;
                r_tag_wr   <= '0;
                r_tag_rd   <= '0;
            end else begin
                if (w_accept) begin
                    r_pc            <= r_pc + ADDR_W'(4);
                    r_tag[r_tag_wr] <= r_pc;
                    r_tag_wr        <= next_ptr(r_tag_wr);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_ONE;
                end
                if (w_push) begin
                    r_fifo_pc[r_fifo_wr]   <= r_tag[r_tag_rd];
                    r_fifo_inst[r_fifo_wr] <= icache_resp_data_i;
                    r_fifo_wr              <= next_ptr(r_fifo_wr);
                    r_tag_rd               <= next_ptr(r_tag_rd);
                end
                if (w_pop) begin
                    r_fifo_rd <= next_ptr(r_fifo_rd);
                end
                if (w_push && !w_pop) begin
                    r_fifo_cnt <= r_fifo_cnt + c_ONE;
                end else if (!w_push && w_pop) begin
                    r_fifo_cnt <= r_fifo_cnt - c_ONE;
                end
            end
        end
    end

    assign icache_req_valid_o  = w_req_valid;
    assign icache_req_addr_o   = r_pc;
    assign icache_data_valid_o = w_pop;
    assign if_valid_o          = w_if_valid;
    assign if_pc_o             = r_fifo_pc[r_fifo_rd];
    assign if_inst_o           = r_fifo_inst[r_fifo_rd];

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit. A small
//               icache model returns inst = addr[31:0] ^ 32'h1000_0000 one
//               cycle after acceptance; responses can be held back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  code;
    logic [63:0] tgt;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        if_ready;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        data_valid;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_pops;
    logic        resp_en;
    logic [31:0] q[$];

    if_fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .ctrl_signal_pc_i    (code),
        .ctrl_to_pc_new_i    (tgt),
        .icache_req_valid_o  (req_valid),
        .icache_req_ready_i  (ready),
        .icache_req_addr_o   (req_addr),
        .icache_resp_valid_i (resp_valid),
        .icache_resp_data_i  (resp_data),
        .icache_data_valid_o (data_valid),
        .if_valid_o          (if_valid),
        .if_ready_i          (if_ready),
        .if_pc_o             (if_pc),
        .if_inst_o           (if_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, present the oldest
    // pending response, then record a request that will be accepted at the
    // next rising edge. Checks after return observe this cycle.
    task automatic step(input logic [1:0] c, input logic rdy, input logic ifr);
        @(negedge clk);
        code     = c;
        ready    = rdy;
        if_ready = ifr;
        if (resp_en && q.size() > 0) begin
            resp_valid = 1'b1;
            resp_data  = q.pop_front();
        end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
        #1;
        if (req_valid && ready) q.push_back(req_addr[31:0] ^ 32'h1000_0000);
    endtask

    // Release reset with a stray response on the bus; cycle 0 must be idle.
    task automatic release_rst();
        @(negedge clk);
        rst        = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        q.delete();
        #1;
        chk("cycle0_no_req", req_valid, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, req_valid, 1'b0);
        chk({tag, "_addr"}, req_addr, 64'h8000_0000);
        chk({tag, "_if_valid"}, if_valid, 1'b0);
        chk({tag, "_data_valid"}, data_valid, 1'b0);
        chk({tag, "_if_pc"}, if_pc, 64'h0);
        chk({tag, "_if_inst"}, {32'h0, if_inst}, 64'h0);
    endtask

    initial begin
        rst = 1'b1; code = 2'b00; tgt = '0; ready = 1'b0; if_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; resp_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst0");

        // ---- streaming --------------------------------------------------
        release_rst();
        n_pops = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'b00, 1'b1, 1'b1);
            if (i == 0) begin
                chk("first_req_valid", req_valid, 1'b1);
                chk("first_req_addr", req_addr, 64'h8000_0000);
            end
            chk("stream_out_le2", 64'(dut.r_out_cnt <= 2), 64'd1);
            if (data_valid) begin
                chk("stream_pc", if_pc, 64'h8000_0000 + 64'(4 * n_pops));
                chk("stream_inst", {32'h0, if_inst}, {32'h0, 32'h9000_0000 + 32'(4 * n_pops)});
                n_pops++;
            end
        end
        chk("stream_pop_count", 64'(n_pops >= 6), 64'd1);

        // ---- reset mid-stream ------------------------------------------
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        chk("rst1_out_cnt", 64'(dut.r_out_cnt), 64'd0);
        repeat (2) @(negedge clk);
        release_rst();

        // ---- back-pressure ---------------------------------------------
        step(2'b00, 1'b1, 1'b1);
        chk("bp_s1_addr", req_addr, 64'h8000_0000);
        chk("bp_s1_fifo_stray", 64'(dut.r_fifo_cnt), 64'd0);
        step(2'b00, 1'b1, 1'b1);
        chk("bp_s2_addr", req_addr, 64'h8000_0004);
        step(2'b00, 1'b1, 1'b1);
        chk("bp_s3_no_req", req_valid, 1'b0);
        chk("bp_s3_pc", if_pc, 64'h8000_0000);
        chk("bp_s3_inst", {32'h0, if_inst}, 64'h9000_0000);
        chk("bp_s3_dv", data_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 1'b1);
            chk("bp_hold_valid", req_valid, 1'b1);
            chk("bp_hold_addr", req_addr, 64'h8000_0008);
            chk("bp_out_le2", 64'(dut.r_out_cnt <= 2), 64'd1);
            if (i == 0) chk("bp_s4_pc", if_pc, 64'h8000_0004);
        end
        step(2'b00, 1'b1, 1'b1);
        chk("bp_s7_addr", req_addr, 64'h8000_0008);
        step(2'b00, 1'b1, 1'b1);
        chk("bp_s8_if_valid", if_valid, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        chk("bp_s9_pc", if_pc, 64'h8000_0008);
        chk("bp_s9_dv", data_valid, 1'b1);

        // ---- redirect with two outstanding -----------------------------
        resp_en = 1'b0;
        step(2'b00, 1'b1, 1'b1);
        chk("rd_s10_pc", if_pc, 64'h8000_000C);
        step(2'b00, 1'b1, 1'b1);
        chk("rd_s11_addr", req_addr, 64'h8000_0014);
        tgt = 64'h8000_1000;
        step(2'b01, 1'b1, 1'b1);
        chk("rd_br_no_req", req_valid, 1'b0);
        chk("rd_br_out", 64'(dut.r_out_cnt), 64'd2);
        resp_en = 1'b1;
        step(2'b00, 1'b1, 1'b1);
        chk("rd_s13_drop", 64'(dut.r_drop_cnt), 64'd2);
        chk("rd_s13_addr", req_addr, 64'h8000_1000);
        chk("rd_s13_no_req", req_valid, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        chk("rd_s14_drop", 64'(dut.r_drop_cnt), 64'd1);
        chk("rd_s14_req", req_valid, 1'b1);
        chk("rd_s14_if_valid", if_valid, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        chk("rd_s15_drop", 64'(dut.r_drop_cnt), 64'd0);
        chk("rd_s15_if_valid", if_valid, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        chk("rd_new_pc", if_pc, 64'h8000_1000);
        chk("rd_new_inst", {32'h0, if_inst}, 64'h9000_1000);
        chk("rd_new_dv", data_valid, 1'b1);

        // ---- hold codes ------------------------------------------------
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b1, 1'b1);
            chk("stall_no_req", req_valid, 1'b0);
            chk("stall_if_valid", if_valid, 1'b0);
            chk("stall_dv", data_valid, 1'b0);
            chk("stall_fifo_full", 64'(dut.r_fifo_cnt), 64'd2);
            chk("stall_head", if_pc, 64'h8000_1004);
        end
        step(2'b10, 1'b1, 1'b1);
        chk("bubble_if_valid", if_valid, 1'b0);
        chk("bubble_dv", data_valid, 1'b0);
        chk("bubble_fifo", 64'(dut.r_fifo_cnt), 64'd2);
        step(2'b00, 1'b1, 1'b1);
        chk("hold_pop1_pc", if_pc, 64'h8000_1004);
        chk("hold_pop1_dv", data_valid, 1'b1);
        step(2'b00, 1'b1, 1'b1);
        chk("hold_pop2_pc", if_pc, 64'h8000_1008);
        chk("hold_pop2_dv", data_valid, 1'b1);

        // ---- branch together with a response ---------------------------
        resp_en = 1'b0;
        step(2'b00, 1'b1, 1'b1);
        chk("sim_s26_if_valid", if_valid, 1'b0);
        resp_en = 1'b1;
        tgt = 64'h8000_2002;
        step(2'b01, 1'b1, 1'b1);
        chk("sim_br_resp", resp_valid, 1'b1);
        chk("sim_br_out", 64'(dut.r_out_cnt), 64'd2);
        step(2'b00, 1'b0, 1'b1);
        chk("sim_drop", 64'(dut.r_drop_cnt), 64'd1);
        chk("sim_fifo_empty", 64'(dut.r_fifo_cnt), 64'd0);
        chk("sim_if_valid", if_valid, 1'b0);
        chk("sim_addr_aligned", req_addr, 64'h8000_2000);
        chk("sim_req", req_valid, 1'b1);
        step(2'b00, 1'b1, 1'b1);
        chk("sim_drop_done", 64'(dut.r_drop_cnt), 64'd0);
        chk("sim_out_zero", 64'(dut.r_out_cnt), 64'd0);
        step(2'b00, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b1);
        chk("sim_new_pc", if_pc, 64'h8000_2000);
        chk("sim_new_inst", {32'h0, if_inst}, 64'h9000_2000);
        chk("sim_new_dv", data_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
